// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate / load-data extender with a 2-entry skid buffer.
// Define EXT_ERR_EN to add the out_err flag for illegal modes and misaligned halfword loads.
module ext_pipe #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IMM_W  = 16,
   parameter int unsigned JIMM_W = 26,
   parameter int unsigned TAG_W  = 5
) (
   input  logic                         CLK,
   input  logic                         nRST,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [3:0]                   mode,
   input  logic [JIMM_W-1:0]            imm,
   input  logic [DATA_W-1:0]            ld_data,
   input  logic [$clog2(DATA_W/8)-1:0]  byte_off,
   input  logic [TAG_W-1:0]             in_tag,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic [TAG_W-1:0]             out_tag
`ifdef EXT_ERR_EN
   ,
   output logic                         out_err
`endif
);

   localparam int unsigned OFF_W = $clog2(DATA_W / 8);

   localparam logic [3:0] ModeZimm = 4'd0;
   localparam logic [3:0] ModeSimm = 4'd1;
   localparam logic [3:0] ModeUimm = 4'd2;
   localparam logic [3:0] ModeZj   = 4'd3;
   localparam logic [3:0] ModeSj   = 4'd4;
   localparam logic [3:0] ModeLb   = 4'd5;
   localparam logic [3:0] ModeLbu  = 4'd6;
   localparam logic [3:0] ModeLh   = 4'd7;
   localparam logic [3:0] ModeLhu  = 4'd8;

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e              state_q, state_d;
   logic                in_ready_q;
   logic                out_valid_q;
   logic                accept;
   logic                load_out_new;
   logic                load_out_skid;
   logic                load_skid;

   logic [DATA_W-1:0]   out_data_q;
   logic [TAG_W-1:0]    out_tag_q;
   logic [DATA_W-1:0]   skid_data_q;
   logic [TAG_W-1:0]    skid_tag_q;

   logic                is_half;
   logic [OFF_W-1:0]    off_eff;
   logic [OFF_W+2:0]    shamt;
   logic [15:0]         lane_h;
   logic [7:0]          lane_b;
   logic [DATA_W-1:0]   res_c;

   // ---------------------------------------------------------------------------------------------
   // Extension datapath
   // ---------------------------------------------------------------------------------------------
   assign is_half = (mode == ModeLh) || (mode == ModeLhu);

   always_comb begin
      off_eff = byte_off;
      if (is_half) begin
         off_eff[0] = 1'b0;
      end
      shamt  = {off_eff, 3'b000};
      // Shift rather than part-select so the top lane never indexes past ld_data.
      lane_h = 16'(ld_data >> shamt);
      lane_b = lane_h[7:0];
   end

   always_comb begin
      res_c = '0;
      case (mode)
         ModeZimm: res_c = {{(DATA_W - IMM_W){1'b0}}, imm[IMM_W-1:0]};
         ModeSimm: res_c = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm[IMM_W-1:0]};
         ModeUimm: res_c = {imm[IMM_W-1:0], {(DATA_W - IMM_W){1'b0}}};
         ModeZj:   res_c = {{(DATA_W - JIMM_W){1'b0}}, imm};
         ModeSj:   res_c = {{(DATA_W - JIMM_W){imm[JIMM_W-1]}}, imm};
         ModeLb:   res_c = {{(DATA_W - 8){lane_b[7]}}, lane_b};
         ModeLbu:  res_c = {{(DATA_W - 8){1'b0}}, lane_b};
         ModeLh:   res_c = {{(DATA_W - 16){lane_h[15]}}, lane_h};
         ModeLhu:  res_c = {{(DATA_W - 16){1'b0}}, lane_h};
         default:  res_c = '0;
      endcase
   end

   // ---------------------------------------------------------------------------------------------
   // Handshake FSM
   // ---------------------------------------------------------------------------------------------
   assign accept = in_valid & in_ready_q;

   always_comb begin
      state_d       = state_q;
      load_out_new  = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      if (flush) begin
         state_d = StEmpty;
      end else begin
         case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_d      = StOne;
                  load_out_new = 1'b1;
               end
            end
            StOne: begin
               if (accept && out_ready) begin
                  load_out_new = 1'b1;
               end else if (accept) begin
                  state_d   = StFull;
                  load_skid = 1'b1;
               end else if (out_ready) begin
                  state_d = StEmpty;
               end
            end
            StFull: begin
               if (out_ready) begin
                  state_d       = StOne;
                  load_out_skid = 1'b1;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q     <= StEmpty;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d != StFull);
         out_valid_q <= (state_d != StEmpty);
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         out_data_q  <= '0;
         out_tag_q   <= '0;
         skid_data_q <= '0;
         skid_tag_q  <= '0;
      end else begin
         if (load_out_new) begin
            out_data_q <= res_c;
            out_tag_q  <= in_tag;
         end else if (load_out_skid) begin
            out_data_q <= skid_data_q;
            out_tag_q  <= skid_tag_q;
         end
         if (load_skid) begin
            skid_data_q <= res_c;
            skid_tag_q  <= in_tag;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_tag   = out_tag_q;

`ifdef EXT_ERR_EN
   logic err_c;
   logic out_err_q;
   logic skid_err_q;

   // The result is still produced for flagged beats; the flag only travels alongside it.
   assign err_c = (mode > ModeLhu) || (is_half && byte_off[0]);

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         out_err_q  <= 1'b0;
         skid_err_q <= 1'b0;
      end else begin
         if (load_out_new) begin
            out_err_q <= err_c;
         end else if (load_out_skid) begin
            out_err_q <= skid_err_q;
         end
         if (load_skid) begin
            skid_err_q <= err_c;
         end
      end
   end

   assign out_err = out_err_q;
`endif

endmodule
